// File: rtl/turbo_iter_ctrl_if.sv
// Handshake and SISO operand bundle for the turbo iteration controller.
// master = controller side, slave = stream source / SISO core / consumer side.
interface turbo_iter_ctrl_if #(
  parameter int unsigned K      = 8,
  parameter int unsigned LLR_W  = 4,
  parameter int unsigned EXT_W  = 10,
  parameter int unsigned ITER_W = 5
);
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [LLR_W-1:0]     in_sys_i;
  logic [LLR_W-1:0]     in_par1_i;
  logic [LLR_W-1:0]     in_par2_i;
  logic                 siso_start_o;
  logic [K*EXT_W-1:0]   siso_sys_o;
  logic [K*EXT_W-1:0]   siso_par_o;
  logic [K*EXT_W-1:0]   siso_apr_o;
  logic [K*EXT_W-1:0]   siso_llr_i;
  logic                 siso_done_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [K-1:0]         out_bits_o;
  logic [ITER_W-1:0]    out_iters_o;
  logic                 out_early_o;

  modport master (
    input  in_valid_i, in_sys_i, in_par1_i, in_par2_i, siso_llr_i, siso_done_i, out_ready_i,
    output in_ready_o, siso_start_o, siso_sys_o, siso_par_o, siso_apr_o,
           out_valid_o, out_bits_o, out_iters_o, out_early_o
  );

  modport slave (
    output in_valid_i, in_sys_i, in_par1_i, in_par2_i, siso_llr_i, siso_done_i, out_ready_i,
    input  in_ready_o, siso_start_o, siso_sys_o, siso_par_o, siso_apr_o,
           out_valid_o, out_bits_o, out_iters_o, out_early_o
  );
endinterface

// File: rtl/turbo_iter_ctrl.sv
// Turbo decoder iteration controller: buffers one block, runs the SISO twice per
// iteration (natural / interleaved), keeps extrinsics and stops on stable decisions.
module turbo_iter_ctrl #(
  parameter int unsigned K          = 8,
  parameter int unsigned LLR_W      = 4,
  parameter int unsigned EXT_W      = 10,
  parameter int unsigned MAX_ITER   = 16,
  parameter int unsigned ITER_W     = 5,
  parameter int unsigned INTLV_MULT = 3
) (
  input  logic              clk_p_i,
  input  logic              reset_n_i,
  turbo_iter_ctrl_if.master bus
);

  localparam int unsigned CNT_W = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [2:0] {LOAD, START1, WAIT1, START2, WAIT2, CHECK, OUT} state_t;
  typedef logic signed [EXT_W-1:0] llr_t;

  state_t             state;
  logic [CNT_W-1:0]   load_cnt;
  logic [ITER_W-1:0]  iter;
  logic [K-1:0]       hd, prev_hd;
  llr_t               sys_buf [K], par1_buf [K], par2_buf [K], ext1 [K], ext2 [K];
  llr_t               sys_w [K], par1_w [K], par2_w [K], ext1_w [K], ext2_w [K];

  logic               in_ready_q, siso_start_q, out_valid_q, out_early_q;
  logic [K*EXT_W-1:0] sys_q, par_q, apr_q;
  logic [K-1:0]       out_bits_q;
  logic [ITER_W-1:0]  out_iters_q;

  logic beat, last_beat, done1, done2, stop_early, stop_max, launch1;

  function automatic int unsigned pi_f(input int unsigned i);
    return (INTLV_MULT * i) % K;
  endfunction

  function automatic llr_t sxt(input logic [LLR_W-1:0] x);
    return llr_t'({{(EXT_W-LLR_W){x[LLR_W-1]}}, x});
  endfunction

  // One guard bit: overflow shows up as the top two bits disagreeing.
  function automatic llr_t sat_sub(input llr_t a, input llr_t b);
    logic signed [EXT_W:0] d;
    d = {a[EXT_W-1], a} - {b[EXT_W-1], b};
    if (d[EXT_W] != d[EXT_W-1])
      return d[EXT_W] ? llr_t'({1'b1, {(EXT_W-1){1'b0}}}) : llr_t'({1'b0, {(EXT_W-1){1'b1}}});
    return d[EXT_W-1:0];
  endfunction

  assign beat       = (state == LOAD) && in_ready_q && bus.in_valid_i;
  assign last_beat  = beat && (load_cnt == CNT_W'(K-1));
  assign done1      = (state == WAIT1) && bus.siso_done_i;
  assign done2      = (state == WAIT2) && bus.siso_done_i;
  assign stop_early = (iter >= ITER_W'(2)) && (hd == prev_hd);
  assign stop_max   = (iter == ITER_W'(MAX_ITER));
  assign launch1    = last_beat || ((state == CHECK) && !stop_early && !stop_max);

  // Next-cycle buffer contents, so a launch can use data written in the same cycle.
  always_comb begin
    sys_w  = sys_buf;
    par1_w = par1_buf;
    par2_w = par2_buf;
    ext1_w = ext1;
    ext2_w = ext2;
    if (beat) begin
      sys_w[load_cnt]  = sxt(bus.in_sys_i);
      par1_w[load_cnt] = sxt(bus.in_par1_i);
      par2_w[load_cnt] = sxt(bus.in_par2_i);
    end
    if (last_beat) begin
      ext1_w = '{default: '0};
      ext2_w = '{default: '0};
    end
    for (int unsigned i = 0; i < K; i++) begin
      if (done1) ext1_w[i] = sat_sub(bus.siso_llr_i[i*EXT_W +: EXT_W], apr_q[i*EXT_W +: EXT_W]);
      if (done2) ext2_w[i] = sat_sub(bus.siso_llr_i[i*EXT_W +: EXT_W], apr_q[i*EXT_W +: EXT_W]);
    end
  end

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state        <= LOAD;
      load_cnt     <= '0;
      iter         <= '0;
      hd           <= '0;
      prev_hd      <= '0;
      sys_buf      <= '{default: '0};
      par1_buf     <= '{default: '0};
      par2_buf     <= '{default: '0};
      ext1         <= '{default: '0};
      ext2         <= '{default: '0};
      in_ready_q   <= 1'b0;
      siso_start_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_early_q  <= 1'b0;
      sys_q        <= '0;
      par_q        <= '0;
      apr_q        <= '0;
      out_bits_q   <= '0;
      out_iters_q  <= '0;
    end else begin
      sys_buf      <= sys_w;
      par1_buf     <= par1_w;
      par2_buf     <= par2_w;
      ext1         <= ext1_w;
      ext2         <= ext2_w;
      siso_start_q <= 1'b0;

      case (state)
        LOAD: begin
          in_ready_q <= 1'b1;
          if (beat) load_cnt <= load_cnt + 1'b1;
          if (last_beat) begin
            load_cnt   <= '0;
            iter       <= '0;
            in_ready_q <= 1'b0;
            state      <= START1;
          end
        end
        START1: state <= WAIT1;
        WAIT1:  if (bus.siso_done_i) state <= START2;
        START2: state <= WAIT2;
        WAIT2: begin
          if (bus.siso_done_i) begin
            for (int unsigned i = 0; i < K; i++)
              hd[pi_f(i)] <= ~bus.siso_llr_i[i*EXT_W + EXT_W - 1];
            iter  <= iter + 1'b1;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (stop_early || stop_max) begin
            out_valid_q <= 1'b1;
            out_bits_q  <= hd;
            out_iters_q <= iter;
            out_early_q <= stop_early;
            state       <= OUT;
          end else begin
            prev_hd <= hd;
            state   <= START1;
          end
        end
        OUT: begin
          if (bus.out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase

      // Half 1: natural order, a-priori is ext2 scattered back through pi.
      if (launch1) begin
        siso_start_q <= 1'b1;
        for (int unsigned i = 0; i < K; i++) begin
          sys_q[i*EXT_W +: EXT_W]       <= sys_w[i];
          par_q[i*EXT_W +: EXT_W]       <= par1_w[i];
          apr_q[pi_f(i)*EXT_W +: EXT_W] <= ext2_w[i];
        end
      end

      // Half 2: interleaved order, parity-2 as encoded.
      if (done1) begin
        siso_start_q <= 1'b1;
        for (int unsigned i = 0; i < K; i++) begin
          sys_q[i*EXT_W +: EXT_W] <= sys_w[pi_f(i)];
          par_q[i*EXT_W +: EXT_W] <= par2_w[i];
          apr_q[i*EXT_W +: EXT_W] <= ext1_w[pi_f(i)];
        end
      end
    end
  end

  assign bus.in_ready_o   = in_ready_q;
  assign bus.siso_start_o = siso_start_q;
  assign bus.siso_sys_o   = sys_q;
  assign bus.siso_par_o   = par_q;
  assign bus.siso_apr_o   = apr_q;
  assign bus.out_valid_o  = out_valid_q;
  assign bus.out_bits_o   = out_bits_q;
  assign bus.out_iters_o  = out_iters_q;
  assign bus.out_early_o  = out_early_q;

endmodule
